// File: rtl/trace_tx_fifo_if.sv
// trace_tx_fifo_if: splitter byte strobe plus UART launch handshake.
// master = environment (splitter + UART), slave = the FIFO.
interface trace_tx_fifo_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx_free;
  logic       transmit;
  logic [7:0] tx_byte;
  modport master(output in_valid, in_data, tx_free, input in_ready, transmit, tx_byte);
  modport slave(input in_valid, in_data, tx_free, output in_ready, transmit, tx_byte);
endinterface

// File: rtl/trace_tx_fifo.sv
// trace_tx_fifo: byte FIFO from packet splitter to UART with tx_free-paced launches,
// hysteretic cts_stop and sticky overflow; TXFIFO_DROPCNT_EN adds a dropped-byte counter.
module trace_tx_fifo #(
  parameter int DEPTH_LOG2   = 8,
  parameter int HWM          = 192,
  parameter int LWM          = 64,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  clkOut,
  input  logic                  rst,
  trace_tx_fifo_if.slave        bus,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  cts_stop,
  output logic [15:0]           drop_count
);
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] CAP   = LW'(2 ** DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] HWM_L = LW'(HWM);
  localparam logic [DEPTH_LOG2:0] LWM_L = LW'(LWM);
  localparam logic [3:0]          BT    = 4'(BUSY_TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_FREE} state_t;
  state_t                state;
  logic [7:0]            mem [2 ** DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [3:0]            timer;
  logic                  push, drop, pop;
  logic [DEPTH_LOG2:0]   level_nxt;
  assign empty        = level == '0;
  assign full         = level == CAP;
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign drop         = bus.in_valid && full;
  assign pop          = state == IDLE && !empty && bus.tx_free;
  assign level_nxt    = level + LW'(push) - LW'(pop);
  always_ff @(posedge clkOut)
    if (push) mem[wptr] <= bus.in_data;
  // cts_stop follows the next level so it changes in the same cycle level crosses a mark
  always_ff @(posedge clkOut)
    if (rst) begin
      wptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      cts_stop <= 1'b0;
    end else begin
      wptr     <= wptr + DEPTH_LOG2'(push);
      level    <= level_nxt;
      overflow <= drop || (overflow && !ovf_clr);
      cts_stop <= level_nxt >= HWM_L ? 1'b1 : level_nxt <= LWM_L ? 1'b0 : cts_stop;
    end
  always_ff @(posedge clkOut)
    if (rst) begin
      state        <= IDLE;
      rptr         <= '0;
      timer        <= '0;
      bus.transmit <= 1'b0;
      bus.tx_byte  <= 8'h00;
    end else begin
      bus.transmit <= 1'b0;
      case (state)
        IDLE:
          if (pop) begin
            bus.tx_byte  <= mem[rptr];
            rptr         <= rptr + 1'b1;
            bus.transmit <= 1'b1;
            timer        <= '0;
            state        <= WAIT_BUSY;
          end
        WAIT_BUSY:
          if (!bus.tx_free) state <= WAIT_FREE;
          else if (timer == BT) state <= IDLE;
          else timer <= timer + 1'b1;
        WAIT_FREE:
          if (bus.tx_free) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef TXFIFO_DROPCNT_EN
  always_ff @(posedge clkOut)
    if (rst) drop_count <= '0;
    else drop_count <= drop ? (ovf_clr ? 16'd1 : drop_count == 16'hFFFF ? drop_count : drop_count + 16'd1)
                            : ovf_clr ? 16'd0 : drop_count;
`else
  assign drop_count = 16'h0000;
`endif
endmodule

// File: tb/tb_trace_tx_fifo.sv
// tb_trace_tx_fifo: directed scoreboard bench for trace_tx_fifo (default parameters).
module tb_trace_tx_fifo;
  logic        clk = 1'b0;
  logic        rst, ovf_clr, overflow, empty, full, cts_stop;
  logic [8:0]  level;
  logic [15:0] drop_count;
  trace_tx_fifo_if bus();
  int          checks = 0, failures = 0, cyc = 0;
  logic [7:0]  q[$];
  always #5 clk = ~clk;
  trace_tx_fifo dut (
    .clkOut(clk), .rst(rst), .bus(bus), .overflow(overflow), .ovf_clr(ovf_clr),
    .level(level), .empty(empty), .full(full), .cts_stop(cts_stop), .drop_count(drop_count)
  );
`ifdef TXFIFO_DROPCNT_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_tx(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.transmit !== 1'b1 && n < budget);
    chk("launch_seen", {31'd0, bus.transmit}, 32'd1);
  endtask
  initial begin
    int exp_level, last, launches;
    logic cts_exp;
    rst = 1'b1; ovf_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.tx_free = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_transmit", bus.transmit, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_cts", cts_stop, 0);
    chk("rst_drop_count", drop_count, 0);
    // single byte latency
    bus.tx_free = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hA5; q.push_back(8'hA5);
    tick();
    bus.in_valid = 1'b0;
    chk("lat_level_n1", level, 1);
    chk("lat_tx_n1", bus.transmit, 0);
    tick();
    chk("lat_tx_n2", bus.transmit, 1);
    chk("lat_byte", bus.tx_byte, q.pop_front());
    chk("lat_level_n2", level, 0);
    tick();
    chk("lat_tx_pulse", bus.transmit, 0);
    repeat (8) tick();
    // fill to full with UART busy
    bus.tx_free = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(i); q.push_back(8'(i));
      tick();
      if (i == 190) chk("cts_at_191", cts_stop, 0);
      if (i == 191) chk("cts_at_192", cts_stop, 1);
    end
    bus.in_data = 8'hEE;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    chk("full_level", level, 256);
    chk("full_flag", full, 1);
    chk("full_in_ready", bus.in_ready, 0);
    chk("drop_overflow", overflow, 1);
    chk("drop_count3", drop_count, DC ? 3 : 0);
    bus.in_valid = 1'b1; ovf_clr = 1'b1;
    tick();
    bus.in_valid = 1'b0; ovf_clr = 1'b0;
    chk("clr_vs_drop_ovf", overflow, 1);
    chk("clr_vs_drop_cnt", drop_count, DC ? 1 : 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_cnt", drop_count, 0);
    // push coinciding with first pop while full is still dropped
    bus.tx_free = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h77;
    tick();
    bus.in_valid = 1'b0;
    chk("pp_full_tx", bus.transmit, 1);
    chk("pp_full_byte", bus.tx_byte, q.pop_front());
    chk("pp_full_level", level, 255);
    chk("pp_full_ovf", overflow, 1);
    bus.tx_free = 1'b0;
    repeat (40) tick();
    bus.tx_free = 1'b1;
    cts_exp = 1'b1;
    for (int k = 1; k < 256; k++) begin
      wait_tx(60);
      chk("drain_byte", bus.tx_byte, q.pop_front());
      exp_level = 255 - k;
      chk("drain_level", level, exp_level);
      cts_exp = exp_level >= 192 ? 1'b1 : exp_level <= 64 ? 1'b0 : cts_exp;
      chk("drain_cts", cts_stop, cts_exp);
      bus.tx_free = 1'b0;
      repeat (40) tick();
      bus.tx_free = 1'b1;
    end
    tick(); tick();
    chk("drain_empty", empty, 1);
    // simultaneous push and pop at level 10
    bus.tx_free = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'h10 + i); q.push_back(8'(8'h10 + i));
      tick();
    end
    bus.in_valid = 1'b0;
    chk("lvl10", level, 10);
    bus.tx_free = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h1A; q.push_back(8'h1A);
    tick();
    bus.in_valid = 1'b0;
    chk("pp_level", level, 10);
    chk("pp_tx", bus.transmit, 1);
    chk("pp_byte", bus.tx_byte, q.pop_front());
    // tx_free never falls: launches paced by the busy timeout
    last = cyc;
    for (int i = 0; i < 10; i++) begin
      wait_tx(12);
      chk("to_byte", bus.tx_byte, q.pop_front());
      chk("to_period", cyc - last, 6);
      last = cyc;
    end
    repeat (8) tick();
    // reset while holding 50 bytes in WAIT_FREE
    bus.tx_free = 1'b0;
    for (int i = 0; i < 51; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'h40 + i); q.push_back(8'(8'h40 + i));
      tick();
    end
    bus.in_valid = 1'b0;
    bus.tx_free = 1'b1;
    wait_tx(5);
    chk("pre_rst_byte", bus.tx_byte, q.pop_front());
    bus.tx_free = 1'b0;
    tick(); tick();
    chk("pre_rst_level", level, 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_tx", bus.transmit, 0);
    chk("mid_rst_empty", empty, 1);
    bus.tx_free = 1'b1;
    launches = 0;
    repeat (20) begin
      tick();
      if (bus.transmit === 1'b1) launches++;
    end
    chk("post_rst_launches", launches, 0);
    chk("post_rst_level", level, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trace_tx_fifo.md
Name: trace_tx_fifo

Overview:
Byte FIFO between the packet splitter (packSend) and the UART transmitter, in the clkOut domain. It absorbs bursts from the splitter while the 12 Mbaud UART drains one byte at a time, and paces UART launches using the UART's tx_free handshake. It also produces a hysteretic flow-control flag for host CTS and a sticky overflow indication that drives the overflow LED.

Parameters:
DEPTH_LOG2, 8, FIFO depth = 2**DEPTH_LOG2 bytes (legal 2..10)
HWM, 192, level at or above which cts_stop asserts
LWM, 64, level at or below which cts_stop deasserts (LWM < HWM < 2**DEPTH_LOG2)
BUSY_TIMEOUT, 4, cycles to wait for tx_free to fall after a launch before treating the byte as taken (1..15)

Ports:
clkOut  in  1  system clock, 48 MHz; all logic on its rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  one-cycle strobe from splitter: in_data valid
in_data  in  8  byte from splitter
in_ready  out  1  = !full; feeds splitter DataNext
overflow  out  1  sticky: a byte was dropped
ovf_clr  in  1  clears overflow
tx_free  in  1  UART transmitter idle
transmit  out  1  one-cycle launch strobe to UART
tx_byte  out  8  byte to UART; stable from launch until next launch
level  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
empty  out  1  level == 0
full  out  1  level == 2**DEPTH_LOG2
cts_stop  out  1  flow-control flag with hysteresis
drop_count  out  16  dropped-byte counter (see Optional Feature)

Behaviour:
- Reset: level=0, empty=1, full=0, in_ready=1, transmit=0, tx_byte=8'h00, overflow=0, cts_stop=0, drop_count=0, FSM=IDLE. Stored data is not cleared. Reset mid-transfer discards the contents; a byte already handed to the UART is the UART's responsibility.
- Storage: circular buffer; read and write pointers of width DEPTH_LOG2 wrap naturally; level is a registered counter.
- Push: in_valid && !full writes at wptr; wptr+1. in_valid && full drops the byte; overflow<=1. A push in the same cycle as a pop while full is still dropped, because full is evaluated on the registered level.
- ovf_clr: overflow<=0 unless a drop occurs in the same cycle; the drop wins and overflow stays 1.
- Pop/launch FSM:
  - IDLE: if !empty && tx_free, then tx_byte<=mem[rptr], rptr+1, transmit<=1 for one cycle, go to WAIT_BUSY with timer=0.
  - WAIT_BUSY: if tx_free==0, go to WAIT_FREE. Otherwise timer+1; at timer==BUSY_TIMEOUT go to IDLE.
  - WAIT_FREE: when tx_free==1, go to IDLE.
- Level: +1 on accepted push, -1 on pop, unchanged when both occur in the same cycle. Never wraps.
- Latency: in_valid at cycle N into an empty FIFO with tx_free=1 gives level=1 at N+1 and transmit=1 with tx_byte=data at N+2.
- Data order is strict FIFO. No byte is duplicated or skipped except drops on full.
- cts_stop: set when level >= HWM; cleared when level <= LWM; holds between the two thresholds.
- empty, full, in_ready are derived combinationally from the registered level.

Optional Feature:
Macro TXFIFO_DROPCNT_EN.
- Defined: drop_count increments by 1 per dropped byte, saturates at 16'hFFFF, and clears on rst or ovf_clr. On a same-cycle drop and ovf_clr, drop_count<=1.
- Undefined: drop_count is tied to 16'h0000 and no counter logic is built.

Test Plan:
- Reset, then a single push of 8'hA5 with tx_free=1 → transmit pulses exactly 2 cycles after in_valid with tx_byte=8'hA5; level goes 0→1→0.
- DEPTH_LOG2=8, tx_free=0, push 256 bytes 0x00..0xFF → full=1, in_ready=0, cts_stop=1 at level 192. Then 3 more pushes → overflow=1; drop_count=3 with TXFIFO_DROPCNT_EN defined, 0 without it.
- Continue from the full state, model UART busy for 40 cycles per byte → output sequence 0x00..0xFF in order; cts_stop stays 1 until level=64, then 0.
- Simultaneous push and pop at level 10 → level stays 10. Push on the same cycle as ovf_clr while full → overflow stays 1.
- tx_free held at 1 constantly (UART never signals busy) → a launch every BUSY_TIMEOUT+2 = 6 cycles, data correct.
- Assert rst while the FIFO holds 50 bytes and the FSM is in WAIT_FREE → next cycle level=0, transmit=0, FSM IDLE, no further launches.
